register_bank: RTL and testbench

- Storage and address-decode stage directly upstream of the one-hot read-word multiplexer.
- Holds the 32×16 register array and accepts binary-addressed writes.
- Converts a binary read address into a registered one-hot select vector and exposes the whole array, so the downstream mux resolves the read word.
- Provides a sequenced clear-all operation that zeroes the array one entry per cycle.

---
 rtl/register_bank_if.sv | 44 ++++
 rtl/register_bank.sv | 134 +++++++++++++
 tb/tb_register_bank.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// register_bank_if: request/response bundle between a register_bank and its
// requester (writes, read-address decode, clear-all control, array view).
//   master: drives WriteEnable/WriteAddress/WriteData, ReadRequest/ReadAddress,
//           ClearStart; observes WriteAccept, ReadAddressDecoded, ReadValid,
//           Busy and RegisterFile.
//   slave : the register bank itself (opposite directions).
// Addresses are binary 0..DEPTH-1 and map to entries 1..DEPTH; entries and
// select bits are numbered from 1.
interface register_bank_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
);

  logic                WriteEnable;
  logic [ADDR_W-1:0]   WriteAddress;
  logic [WIDTH:1]      WriteData;
  logic                WriteAccept;

  logic                ReadRequest;
  logic [ADDR_W-1:0]   ReadAddress;
  logic [DEPTH:1]      ReadAddressDecoded;
  logic                ReadValid;

  logic                ClearStart;
  logic                Busy;

  logic [WIDTH:1]      RegisterFile [1:DEPTH];

  modport master (
    output WriteEnable, WriteAddress, WriteData,
    output ReadRequest, ReadAddress,
    output ClearStart,
    input  WriteAccept, ReadAddressDecoded, ReadValid, Busy, RegisterFile
  );

  modport slave (
    input  WriteEnable, WriteAddress, WriteData,
    input  ReadRequest, ReadAddress,
    input  ClearStart,
    output WriteAccept, ReadAddressDecoded, ReadValid, Busy, RegisterFile
  );

endinterface

// File: rtl/register_bank.sv
// register_bank: 32x16 register storage with binary-addressed writes, a
// registered one-hot read-select decoder feeding an external one-hot mux, and
// a sequenced clear-all that zeroes one entry per cycle.
// Ports:
//   Clock : rising-edge clock for all state.
//   Reset : synchronous, active-high; overrides everything, including a clear.
//   bus   : register_bank_if.slave (write port, read decode, clear control,
//           Busy, and the whole array exposed as RegisterFile[1..DEPTH]).
// Configuration macro:
//   REGFILE_ZERO_REG_EN : entry 1 (address 0) is hardwired to zero; writes to
//                         address 0 are still accepted but discarded.
module register_bank #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic           Clock,
  input  logic           Reset,
  register_bank_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bankStateT;

  bankStateT          state;
  bankStateT          stateNext;
  logic [ADDR_W-1:0]  clearCount;
  logic [ADDR_W-1:0]  clearCountNext;
  logic               busyQ;

  logic               storeEn;
  logic [ADDR_W-1:0]  storeAddr;
  logic [WIDTH:1]     storeData;
  logic               writeKept;

  logic [WIDTH:1]     storage [DEPTH];

  // Writes that survive the zero-register rule
`ifdef REGFILE_ZERO_REG_EN
  assign writeKept = (bus.WriteAddress != '0);
`else
  assign writeKept = 1'b1;
`endif

  // Writes are only taken while no clear sweep is running
  assign bus.WriteAccept = bus.WriteEnable & ~busyQ;

  // State and sweep-counter registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      clearCount <= '0;
      busyQ      <= 1'b0;
    end else begin
      state      <= stateNext;
      clearCount <= clearCountNext;
      busyQ      <= (stateNext == CLEAR);
    end
  end

  // Next-state logic and the single storage write port (user write or sweep)
  always_comb begin
    stateNext      = state;
    clearCountNext = clearCount;
    storeEn        = 1'b0;
    storeAddr      = '0;
    storeData      = '0;
    case (state)
      IDLE: begin
        if (bus.WriteEnable && writeKept) begin
          storeEn   = 1'b1;
          storeAddr = bus.WriteAddress;
          storeData = bus.WriteData;
        end
        // A write in the same cycle still lands; the sweep zeroes it later
        if (bus.ClearStart) begin
          stateNext      = CLEAR;
          clearCountNext = '0;
        end
      end
      CLEAR: begin
        storeEn        = 1'b1;
        storeAddr      = clearCount;
        storeData      = '0;
        clearCountNext = clearCount + ADDR_W'(1);
        if (clearCount == LAST_INDEX) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext      = IDLE;
        clearCountNext = '0;
      end
    endcase
  end

  assign bus.Busy = busyQ;

  // Storage array
  always_ff @(posedge Clock) begin
    if (Reset) begin
      storage <= '{default: '0};
    end else if (storeEn) begin
      storage[storeAddr] <= storeData;
    end
  end

  // Registered one-hot read select; bit ReadAddress+1 of [DEPTH:1]
  always_ff @(posedge Clock) begin
    if (Reset) begin
      bus.ReadAddressDecoded <= '0;
      bus.ReadValid          <= 1'b0;
    end else if (bus.ReadRequest) begin
      bus.ReadAddressDecoded <= DEPTH'(1) << bus.ReadAddress;
      bus.ReadValid          <= 1'b1;
    end else begin
      bus.ReadAddressDecoded <= '0;
      bus.ReadValid          <= 1'b0;
    end
  end

  // Array view: storage[0] is entry 1
  always_comb begin
    bus.RegisterFile = storage;
`ifdef REGFILE_ZERO_REG_EN
    bus.RegisterFile[1] = '0;
`endif
  end

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed scenarios plus random traffic on register_bank,
// checked every cycle against an array-based model of the bank.
module tb_register_bank;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 32;
  localparam int unsigned ADDR_W = 5;

  logic Clock = 1'b0;
  logic Reset;

  always #5 Clock = ~Clock;

  register_bank_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  register_bank #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  bit          checkEn     = 1'b0;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  // Model: entries 1..32, pending sweep position, last read request
  logic [WIDTH:1] model [1:DEPTH];
  bit             mClearing = 1'b0;
  int             mNext     = 1;
  bit             mValid    = 1'b0;
  int             mSel      = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) begin
    if (Reset) begin
      for (int i = 1; i <= DEPTH; i++) model[i] = '0;
      mClearing = 1'b0;
      mNext     = 1;
      mValid    = 1'b0;
    end else begin
      mValid = bus.ReadRequest;
      mSel   = int'(bus.ReadAddress) + 1;
      if (mClearing) begin
        model[mNext] = '0;
        if (mNext == DEPTH) mClearing = 1'b0;
        else mNext++;
      end else begin
        if (bus.WriteEnable && !(ZERO_REG && bus.WriteAddress == '0))
          model[int'(bus.WriteAddress) + 1] = bus.WriteData;
        if (bus.ClearStart) begin
          mClearing = 1'b1;
          mNext     = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge Clock) begin
    logic [DEPTH:1] expSel;
    if (checkEn) begin
      expSel = '0;
      if (mValid) expSel[mSel] = 1'b1;
      check("Busy", 64'(bus.Busy), 64'(mClearing));
      check("ReadValid", 64'(bus.ReadValid), 64'(mValid));
      check("ReadAddressDecoded", 64'(bus.ReadAddressDecoded), 64'(expSel));
      check("WriteAccept", 64'(bus.WriteAccept), 64'(bus.WriteEnable && !mClearing));
      for (int i = 1; i <= DEPTH; i++)
        check($sformatf("RegisterFile[%0d]", i), 64'(bus.RegisterFile[i]), 64'(model[i]));
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic quiet();
    bus.WriteEnable  = 1'b0;
    bus.WriteAddress = '0;
    bus.WriteData    = '0;
    bus.ReadRequest  = 1'b0;
    bus.ReadAddress  = '0;
    bus.ClearStart   = 1'b0;
  endtask

  task automatic fillAll(input logic [WIDTH:1] value);
    for (int a = 0; a < DEPTH; a++) begin
      bus.WriteEnable  = 1'b1;
      bus.WriteAddress = ADDR_W'(a);
      bus.WriteData    = value;
      tick();
    end
    quiet();
  endtask

  task automatic expectAllZero(input string tag);
    for (int i = 1; i <= DEPTH; i++)
      check($sformatf("%s entry%0d", tag, i), 64'(bus.RegisterFile[i]), 64'h0);
  endtask

  initial begin
    int busyCycles;
    logic [WIDTH:1] entry1Exp;
    quiet();
    Reset = 1'b1;
    tick();
    Reset   = 1'b0;
    checkEn = 1'b1;

    // Reset with non-zero contents
    fillAll(16'hFFFF);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst Busy", 64'(bus.Busy), 64'h0);
    check("rst ReadValid", 64'(bus.ReadValid), 64'h0);
    check("rst Decoded", 64'(bus.ReadAddressDecoded), 64'h0);
    expectAllZero("rst");

    // Write then read address 7
    bus.WriteEnable = 1'b1; bus.WriteAddress = 5'd7; bus.WriteData = 16'hA5A5;
    tick();
    quiet();
    bus.ReadRequest = 1'b1; bus.ReadAddress = 5'd7;
    tick();
    quiet();
    check("rd7 Decoded", 64'(bus.ReadAddressDecoded), 64'h0000_0080);
    check("rd7 ReadValid", 64'(bus.ReadValid), 64'h1);
    check("rd7 entry8", 64'(bus.RegisterFile[8]), 64'hA5A5);

    // Same-cycle write and read at address 31
    bus.WriteEnable = 1'b1; bus.WriteAddress = 5'd31; bus.WriteData = 16'h1234;
    bus.ReadRequest = 1'b1; bus.ReadAddress = 5'd31;
    tick();
    quiet();
    check("rw31 Decoded", 64'(bus.ReadAddressDecoded), 64'h8000_0000);
    check("rw31 entry32", 64'(bus.RegisterFile[32]), 64'h1234);

    // Clear-all sweep with a dropped write and reads mid-sweep
    fillAll(16'h00FF);
    bus.ClearStart = 1'b1;
    tick();
    quiet();
    busyCycles = 0;
    for (int c = 1; c <= 40; c++) begin
      if (bus.Busy) busyCycles++;
      if (c == 11) begin
        check("clr rd@10 Decoded", 64'(bus.ReadAddressDecoded), 64'h0010_0000);
        check("clr rd@10 entry21", 64'(bus.RegisterFile[21]), 64'h00FF);
      end
      if (c == 26) begin
        check("clr rd@25 Decoded", 64'(bus.ReadAddressDecoded), 64'h0010_0000);
        check("clr rd@25 entry21", 64'(bus.RegisterFile[21]), 64'h0);
      end
      quiet();
      if (c == 5) begin
        bus.WriteEnable = 1'b1; bus.WriteAddress = 5'd3; bus.WriteData = 16'h1234;
        #1;
        check("clr WriteAccept", 64'(bus.WriteAccept), 64'h0);
      end
      if (c == 10 || c == 25) begin
        bus.ReadRequest = 1'b1; bus.ReadAddress = 5'd20;
      end
      tick();
    end
    quiet();
    check("clr busy cycles", 64'(busyCycles), 64'd32);
    expectAllZero("clr");

    // Reset in the middle of a sweep, then restart
    fillAll(16'h5A5A);
    bus.ClearStart = 1'b1;
    tick();
    quiet();
    for (int c = 1; c < 12; c++) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("midrst Busy", 64'(bus.Busy), 64'h0);
    expectAllZero("midrst");
    fillAll(16'h5A5A);
    bus.ClearStart = 1'b1;
    tick();
    quiet();
    check("restart Busy", 64'(bus.Busy), 64'h1);
    tick();
    check("restart entry1", 64'(bus.RegisterFile[1]), 64'h0);
    check("restart entry2", 64'(bus.RegisterFile[2]), 64'h5A5A);
    for (int c = 0; c < 34; c++) tick();

    // Address 0 write: hardwired zero or ordinary register
    bus.WriteEnable = 1'b1; bus.WriteAddress = 5'd0; bus.WriteData = 16'hBEEF;
    #1;
    check("addr0 WriteAccept", 64'(bus.WriteAccept), 64'h1);
    tick();
    quiet();
    entry1Exp = ZERO_REG ? 16'h0000 : 16'hBEEF;
    check("addr0 entry1", 64'(bus.RegisterFile[1]), 64'(entry1Exp));

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bus.WriteEnable  = ($urandom_range(0, 1) == 1);
      bus.WriteAddress = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.WriteData    = WIDTH'($urandom);
      bus.ReadRequest  = ($urandom_range(0, 9) < 6);
      bus.ReadAddress  = ADDR_W'($urandom_range(0, DEPTH - 1));
      bus.ClearStart   = ($urandom_range(0, 59) == 0);
      Reset            = ($urandom_range(0, 299) == 0);
      tick();
    end
    quiet();
    Reset = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
